m68k_bus_ctrl: RTL and testbench
================================

// Module: m68k_bus_ctrl
//
// PURPOSE
//   68000 bus-cycle controller that sits directly downstream of the address decoder.
//   Consumes the decoded region selects and the CPU strobes, then generates DTACK_n.
//   Inserts region-specific wait states:
//     - SDRAM req/ack handshake for program ROM.
//     - Fixed latency for block RAMs (work RAM, sprite RAM, shared RAM, palettes).
//     - Zero wait for registers.
//   Issues a one-cycle write strobe to block RAMs and registers.
//   Recovers unmapped or hung accesses with a timeout.
//
// PARAMETERS
//   BRAM_WAIT  2    extra clk cycles before DTACK for block-RAM regions (0..15)
//   TIMEOUT    255  clk cycles a cycle may wait for any target before forced DTACK (8-bit)
//
// PORTS
//   clk          in   1  system clock
//   reset_n      in   1  asynchronous, active-low reset
//   cpu_as_n     in   1  68K address strobe
//   cpu_rw       in   1  68K read(1)/write(0)
//   prog_rom_cs  in   1  program ROM region select
//   bram_cs      in   1  OR of ram/sprite_ram/shared_ram/tile_palette/sprite_palette selects
//   reg_cs       in   1  OR of all register selects (scroll, crtc, int_en, flip, reset_z80...)
//   rom_ack      in   1  SDRAM data valid for current rom_req (level)
//   dtack_n      out  1  68K data acknowledge
//   rom_req      out  1  SDRAM read request, held until rom_ack
//   wr_stb       out  1  one-clk write pulse for bram/reg targets
//   timeout_err  out  1  one-clk pulse when a cycle is terminated by timeout
//
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     - state=IDLE; dtack_n=1, rom_req=0, wr_stb=0, timeout_err=0; wait/timeout counters=0.
//   Timing
//     - All outputs are registered; inputs are sampled on rising clk.
//   States: IDLE, WAIT_BRAM, WAIT_ROM, WAIT_NONE, ACK
//   IDLE
//     - Exits only when cpu_as_n=0 is sampled.
//     - Region priority if several selects are high: prog_rom > bram > reg > none.
//     - prog_rom, read  -> WAIT_ROM, rom_req<=1.
//     - prog_rom, write -> ACK directly; no rom_req, no wr_stb (ROM write ignored).
//     - bram -> WAIT_BRAM with counter=0. If BRAM_WAIT=0, go straight to ACK.
//     - reg  -> ACK.
//     - no select -> WAIT_NONE.
//   WAIT_BRAM
//     - Counter increments each clk.
//     - At count==BRAM_WAIT-1, go to ACK.
//   WAIT_ROM
//     - When rom_ack=1 is sampled: rom_req<=0, go to ACK.
//   WAIT_NONE
//     - Holds until timeout.
//   Timeout counter
//     - Runs in every WAIT_* state.
//     - At count==TIMEOUT: go to ACK, pulse timeout_err for 1 clk, drop rom_req.
//   Entering ACK
//     - dtack_n<=0.
//     - wr_stb<=1 for exactly one clk if cpu_rw=0 and region is bram or reg.
//   ACK
//     - dtack_n held low while cpu_as_n=0.
//     - When cpu_as_n=1 is sampled: dtack_n<=1, go to IDLE.
//     - No new cycle can start in the same clk.
//   Latency (AS_n sampled low at edge N)
//     - reg: dtack_n low after edge N+1.
//     - bram: dtack_n low after edge N+1+BRAM_WAIT.
//     - rom: dtack_n low one edge after rom_ack is sampled high.
//   Abort
//     - If cpu_as_n=1 is sampled in any WAIT_* state: go to IDLE, rom_req<=0.
//     - No dtack, no wr_stb, no timeout_err.
//   Simultaneous events
//     - rom_ack and timeout in the same clk: treat as ack, no timeout_err.
//     - rom_ack arriving while not in WAIT_ROM is ignored.
//   Reset mid-cycle
//     - All outputs return to reset values immediately, without waiting for clk.
//
// TESTING
//   1. reg write, AS_n low at edge 0
//      -> dtack_n=0 after edge 1; wr_stb high for exactly 1 clk; dtack_n=1 one clk after AS_n rises.
//   2. bram read, BRAM_WAIT=2
//      -> dtack_n low after edge 3; wr_stb stays 0.
//   3. prog_rom read, rom_ack raised 5 clks after rom_req
//      -> rom_req drops and dtack_n falls on the following edge.
//   4. No select, AS_n held low, TIMEOUT=255
//      -> dtack_n low after 256 wait clks; timeout_err pulses once.
//   5. prog_rom read, AS_n released at clk 3 before any rom_ack
//      -> rom_req=0, dtack_n stays 1, state IDLE; a late rom_ack is ignored.
//   6. reset_n pulsed low while in ACK with dtack_n=0
//      -> dtack_n=1 asynchronously; next AS_n low starts a clean cycle.

Source files
------------

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: turns decoded region selects and CPU strobes into
// DTACK_n with per-region wait states, write strobes, and a hung-cycle timeout.
module m68k_bus_ctrl #(
  parameter int BRAM_WAIT = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_as_n,
  input  logic cpu_rw,
  input  logic prog_rom_cs,
  input  logic bram_cs,
  input  logic reg_cs,
  input  logic rom_ack,
  output logic dtack_n,
  output logic rom_req,
  output logic wr_stb,
  output logic timeout_err
);

  typedef enum logic [2:0] {IDLE, WAIT_BRAM, WAIT_ROM, WAIT_NONE, ACK} state_t;

  localparam logic [3:0] BW_LAST = (BRAM_WAIT > 0) ? 4'(BRAM_WAIT - 1) : 4'd0;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       dtack_n_q, dtack_n_d;
  logic       rom_req_q, rom_req_d;
  logic       wr_stb_q, wr_stb_d;
  logic       timeout_err_q, timeout_err_d;
  logic       wr_pend_q, wr_pend_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       to_expired;

  assign to_expired = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    dtack_n_d     = dtack_n_q;
    rom_req_d     = rom_req_q;
    wr_stb_d      = 1'b0;
    timeout_err_d = 1'b0;
    wr_pend_d     = wr_pend_q;
    wait_cnt_d    = wait_cnt_q;
    to_cnt_d      = to_cnt_q;
    case (state_q)
      IDLE: begin
        dtack_n_d  = 1'b1;
        rom_req_d  = 1'b0;
        wr_pend_d  = 1'b0;
        wait_cnt_d = 4'd0;
        to_cnt_d   = 8'd0;
        if (!cpu_as_n) begin
          if (prog_rom_cs) begin
            // ROM writes are acknowledged but otherwise dropped
            if (cpu_rw) begin
              state_d   = WAIT_ROM;
              rom_req_d = 1'b1;
            end else begin
              state_d = ACK;
            end
          end else if (bram_cs) begin
            wr_pend_d = !cpu_rw;
            state_d   = (BRAM_WAIT == 0) ? ACK : WAIT_BRAM;
          end else if (reg_cs) begin
            wr_pend_d = !cpu_rw;
            state_d   = ACK;
          end else begin
            state_d = WAIT_NONE;
          end
        end
      end
      WAIT_BRAM: begin
        to_cnt_d   = to_cnt_q + 8'd1;
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (cpu_as_n) begin
          state_d   = IDLE;
          wr_pend_d = 1'b0;
        end else if (wait_cnt_q == BW_LAST) begin
          state_d = ACK;
        end else if (to_expired) begin
          state_d       = ACK;
          timeout_err_d = 1'b1;
        end
      end
      WAIT_ROM: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (cpu_as_n) begin
          state_d   = IDLE;
          rom_req_d = 1'b0;
        end else if (rom_ack) begin
          // ack wins over a coincident timeout
          state_d   = ACK;
          rom_req_d = 1'b0;
        end else if (to_expired) begin
          state_d       = ACK;
          rom_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      WAIT_NONE: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (cpu_as_n) begin
          state_d = IDLE;
        end else if (to_expired) begin
          state_d       = ACK;
          timeout_err_d = 1'b1;
        end
      end
      ACK: begin
        if (cpu_as_n) begin
          state_d   = IDLE;
          dtack_n_d = 1'b1;
          wr_pend_d = 1'b0;
        end else begin
          dtack_n_d = 1'b0;
          // dtack_n still high marks the first ACK clock: strobe once
          wr_stb_d  = dtack_n_q & wr_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dtack_n_q     <= 1'b1;
      rom_req_q     <= 1'b0;
      wr_stb_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      wr_pend_q     <= 1'b0;
      wait_cnt_q    <= 4'd0;
      to_cnt_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      dtack_n_q     <= dtack_n_d;
      rom_req_q     <= rom_req_d;
      wr_stb_q      <= wr_stb_d;
      timeout_err_q <= timeout_err_d;
      wr_pend_q     <= wr_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign dtack_n     = dtack_n_q;
  assign rom_req     = rom_req_q;
  assign wr_stb      = wr_stb_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl (BRAM_WAIT=2, TIMEOUT=255); edge 0 is the
// clock edge at which AS_n is first sampled low.
module tb_m68k_bus_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic cpu_as_n, cpu_rw, prog_rom_cs, bram_cs, reg_cs, rom_ack;
  logic dtack_n, rom_req, wr_stb, timeout_err;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   pulses;

  m68k_bus_ctrl #(.BRAM_WAIT(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .prog_rom_cs(prog_rom_cs), .bram_cs(bram_cs), .reg_cs(reg_cs),
    .rom_ack(rom_ack), .dtack_n(dtack_n), .rom_req(rom_req),
    .wr_stb(wr_stb), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    cpu_as_n = 1'b1; cpu_rw = 1'b1;
    prog_rom_cs = 1'b0; bram_cs = 1'b0; reg_cs = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rom_ack = 1'b0;
    idle_bus();
    tick(); tick();
    check("rst_dtack", 16'(dtack_n), 16'd1);
    check("rst_romreq", 16'(rom_req), 16'd0);
    check("rst_wrstb", 16'(wr_stb), 16'd0);
    check("rst_terr", 16'(timeout_err), 16'd0);
    reset_n = 1'b1;
    tick();

    // 1: register write
    cpu_as_n = 1'b0; cpu_rw = 1'b0; reg_cs = 1'b1;
    tick();
    check("reg_wr_e0_dtack", 16'(dtack_n), 16'd1);
    check("reg_wr_e0_wrstb", 16'(wr_stb), 16'd0);
    tick();
    check("reg_wr_e1_dtack", 16'(dtack_n), 16'd0);
    check("reg_wr_e1_wrstb", 16'(wr_stb), 16'd1);
    tick();
    check("reg_wr_e2_dtack", 16'(dtack_n), 16'd0);
    check("reg_wr_e2_wrstb", 16'(wr_stb), 16'd0);
    idle_bus();
    tick();
    check("reg_wr_release", 16'(dtack_n), 16'd1);
    tick();

    // 2: bram read, two wait clocks
    cpu_as_n = 1'b0; cpu_rw = 1'b1; bram_cs = 1'b1;
    tick(); tick(); tick();
    check("bram_rd_e2_dtack", 16'(dtack_n), 16'd1);
    tick();
    check("bram_rd_e3_dtack", 16'(dtack_n), 16'd0);
    check("bram_rd_e3_wrstb", 16'(wr_stb), 16'd0);
    idle_bus();
    tick();
    check("bram_rd_release", 16'(dtack_n), 16'd1);
    tick();

    // bram write: strobe coincides with dtack fall
    cpu_as_n = 1'b0; cpu_rw = 1'b0; bram_cs = 1'b1;
    tick(); tick(); tick();
    check("bram_wr_e2_wrstb", 16'(wr_stb), 16'd0);
    tick();
    check("bram_wr_e3_dtack", 16'(dtack_n), 16'd0);
    check("bram_wr_e3_wrstb", 16'(wr_stb), 16'd1);
    tick();
    check("bram_wr_e4_wrstb", 16'(wr_stb), 16'd0);
    idle_bus();
    tick(); tick();

    // bram beats reg when both selected: reg latency must not apply
    cpu_as_n = 1'b0; cpu_rw = 1'b1; bram_cs = 1'b1; reg_cs = 1'b1;
    tick(); tick();
    check("prio_bram_e1_dtack", 16'(dtack_n), 16'd1);
    tick(); tick();
    check("prio_bram_e3_dtack", 16'(dtack_n), 16'd0);
    idle_bus();
    tick(); tick();

    // 3: prog ROM read, ack 5 clocks after request
    cpu_as_n = 1'b0; cpu_rw = 1'b1; prog_rom_cs = 1'b1;
    tick();
    check("rom_e0_req", 16'(rom_req), 16'd1);
    for (int i = 0; i < 5; i++) tick();
    check("rom_e5_req", 16'(rom_req), 16'd1);
    check("rom_e5_dtack", 16'(dtack_n), 16'd1);
    rom_ack = 1'b1;
    tick();
    check("rom_ack_req", 16'(rom_req), 16'd0);
    check("rom_ack_dtack", 16'(dtack_n), 16'd1);
    tick();
    check("rom_ack_next_dtack", 16'(dtack_n), 16'd0);
    check("rom_rd_wrstb", 16'(wr_stb), 16'd0);
    rom_ack = 1'b0;
    idle_bus();
    tick();
    check("rom_release", 16'(dtack_n), 16'd1);
    tick();

    // ROM write with every select high: acked, no request, no strobe
    cpu_as_n = 1'b0; cpu_rw = 1'b0; prog_rom_cs = 1'b1; bram_cs = 1'b1; reg_cs = 1'b1;
    tick();
    check("rom_wr_e0_req", 16'(rom_req), 16'd0);
    tick();
    check("rom_wr_e1_dtack", 16'(dtack_n), 16'd0);
    check("rom_wr_e1_wrstb", 16'(wr_stb), 16'd0);
    idle_bus();
    tick(); tick();

    // 4: unmapped access times out
    cpu_as_n = 1'b0; cpu_rw = 1'b1;
    tick();
    n = 0;
    pulses = 0;
    while (timeout_err !== 1'b1 && n < 300) begin
      if (dtack_n !== 1'b1) pulses = 100;
      tick();
      n++;
    end
    check("to_edges", 16'(n), 16'd256);
    check("to_early_dtack", 16'(pulses), 16'd0);
    check("to_dtack_at_pulse", 16'(dtack_n), 16'd1);
    pulses = 1;
    tick();
    check("to_dtack", 16'(dtack_n), 16'd0);
    for (int i = 0; i < 5; i++) begin
      if (timeout_err === 1'b1) pulses++;
      tick();
    end
    check("to_pulses", 16'(pulses), 16'd1);
    idle_bus();
    tick();
    check("to_release", 16'(dtack_n), 16'd1);
    tick();

    // 5: ROM read aborted before ack; late ack ignored
    cpu_as_n = 1'b0; cpu_rw = 1'b1; prog_rom_cs = 1'b1;
    tick(); tick(); tick();
    check("abort_req_hold", 16'(rom_req), 16'd1);
    idle_bus();
    tick();
    check("abort_req", 16'(rom_req), 16'd0);
    check("abort_dtack", 16'(dtack_n), 16'd1);
    rom_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (dtack_n !== 1'b1 || rom_req !== 1'b0 || timeout_err !== 1'b0 || wr_stb !== 1'b0)
        pulses++;
      tick();
    end
    check("late_ack_quiet", 16'(pulses), 16'd0);
    rom_ack = 1'b0;
    cpu_as_n = 1'b0; reg_cs = 1'b1;
    tick(); tick();
    check("post_abort_reg_dtack", 16'(dtack_n), 16'd0);
    idle_bus();
    tick(); tick();

    // 6: async reset while in ACK
    cpu_as_n = 1'b0; cpu_rw = 1'b1; reg_cs = 1'b1;
    tick(); tick();
    check("pre_rst_dtack", 16'(dtack_n), 16'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dtack", 16'(dtack_n), 16'd1);
    idle_bus();
    tick();
    #2 reset_n = 1'b1;
    tick();
    cpu_as_n = 1'b0; cpu_rw = 1'b0; reg_cs = 1'b1;
    tick();
    check("clean_e0_dtack", 16'(dtack_n), 16'd1);
    tick();
    check("clean_e1_dtack", 16'(dtack_n), 16'd0);
    check("clean_e1_wrstb", 16'(wr_stb), 16'd1);
    idle_bus();
    tick();
    check("clean_release", 16'(dtack_n), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
